// File: rtl/serial_receive.sv
// serial_receive: oversampling 8O1 frame receiver with parity/stop checks and a valid/ack hand-off
module serial_receive #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] END = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, prev_q;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic par_q, par_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic start_det, done;
  // prev_q resets low, so a line held low through reset never looks like a falling edge
  assign start_det = (state_q == IDLE) & prev_q & ~sync2_q;
  always_comb begin
    state_d = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    par_d = par_q;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        state_d = start_det ? START : IDLE;
      end
      START: if (clk_cnt_q == MID) begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d = sync2_q ? IDLE : DATA;
      end
      DATA: if (clk_cnt_q == END) begin
        clk_cnt_d = '0;
        shift_d[bit_cnt_q] = sync2_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
      end
      PARITY: if (clk_cnt_q == END) begin
        clk_cnt_d = '0;
        par_d = sync2_q;
        state_d = STOP;
      end
      STOP: if (clk_cnt_q == END) begin
        clk_cnt_d = '0;
        done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    data_d = done ? shift_q : data_q;
    perr_d = done ? ~(^{shift_q, par_q}) : perr_q;
    ferr_d = done ? ~sync2_q : ferr_q;
    valid_d = done | (valid_q & ~rx_ack);
    ovr_d = done ? (valid_q & ~rx_ack) : (ovr_q & ~(valid_q & rx_ack));
  end
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q <= IDLE;
      {sync1_q, sync2_q, prev_q} <= '0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      data_q <= '0;
      {valid_q, perr_q, ferr_q, ovr_q} <= '0;
    end else begin
      state_q <= state_d;
      {sync1_q, sync2_q, prev_q} <= {serial_in, sync1_q, sync2_q};
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      data_q <= data_d;
      {valid_q, perr_q, ferr_q, ovr_q} <= {valid_d, perr_d, ferr_d, ovr_d};
    end
  end
  assign data_out = data_q;
  assign rx_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
  assign rx_busy = (state_q != IDLE) | start_det;
endmodule

// File: tb/tb_serial_receive.sv
// tb_serial_receive: random and directed frames against a history-based frame model
module tb_serial_receive;
  logic ref_clk = 1'b0, reset = 1'b1, serial_in = 1'b1, rx_ack = 1'b0;
  logic [7:0] data_out;
  logic rx_valid, parity_err, frame_err, overrun, rx_busy;
  int n_cmp = 0, n_bad = 0;
  bit rand_done = 0;
  serial_receive #(.CLKS_PER_BIT(16)) dut (
    .ref_clk(ref_clk), .reset(reset), .serial_in(serial_in), .rx_ack(rx_ack),
    .data_out(data_out), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );
  always #5 ref_clk = ~ref_clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask
  // Model: remembers the synchronized line per cycle and decodes a frame from
  // the mid-bit samples d+8, d+24+16*i, d+152, d+168 once the stop sample is reached.
  bit m_s1, m_s2, m_p, m_busy, m_valid, m_perr, m_ferr, m_ovr;
  logic [7:0] m_data = '0, m_byte;
  int m_d, cyc = 0;
  bit hist [131072];
  always @(negedge ref_clk) begin : model
    bit start, comp;
    start = !m_busy && m_p && !m_s2;
    chk("data_out", data_out, m_data);
    chk("rx_valid", rx_valid, m_valid);
    chk("parity_err", parity_err, m_perr);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
    chk("rx_busy", rx_busy, start | m_busy);
    if (reset) begin
      {m_s1, m_s2, m_p, m_busy, m_valid, m_perr, m_ferr, m_ovr} = '0;
      m_data = '0;
    end else begin
      hist[cyc] = m_s2;
      comp = 0;
      if (start) begin
        m_busy = 1;
        m_d = cyc;
      end else if (m_busy && cyc == m_d + 8 && m_s2) m_busy = 0;
      else if (m_busy && cyc == m_d + 168) begin
        for (int i = 0; i < 8; i++) m_byte[i] = hist[m_d + 24 + 16 * i];
        comp = 1;
        m_busy = 0;
      end
      if (comp) begin
        m_ovr = m_valid && !rx_ack;
        m_data = m_byte;
        m_perr = ((($countones(m_byte) + int'(hist[m_d + 152])) % 2) == 0);
        m_ferr = !m_s2;
        m_valid = 1;
      end else if (m_valid && rx_ack) begin
        m_valid = 0;
        m_ovr = 0;
      end
      m_p = m_s2;
      m_s2 = m_s1;
      m_s1 = serial_in;
    end
    cyc++;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ref_clk);
      #1;
    end
  endtask
  task automatic drive(input logic v, input int n);
    serial_in = v;
    tick(n);
  endtask
  task automatic send(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) drive(f[i], 16);
  endtask
  task automatic ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask
  initial begin
    tick(4);
    reset = 1'b0;
    drive(1'b1, 20);
    chk("reset_valid", rx_valid, 0);
    fork
      send(8'hA5, 1'b1, 1'b1);
      begin
        tick(1); chk("a5_busy_d-1", rx_busy, 0);
        tick(1); chk("a5_busy_d", rx_busy, 1);
        tick(168); chk("a5_busy_d168", rx_busy, 1); chk("a5_valid_d168", rx_valid, 0);
        tick(1); chk("a5_valid_d169", rx_valid, 1); chk("a5_data", data_out, 8'hA5);
        chk("a5_perr", parity_err, 0); chk("a5_ferr", frame_err, 0); chk("a5_busy_d169", rx_busy, 0);
      end
    join
    ack();
    chk("a5_acked", rx_valid, 0);
    send(8'h01, 1'b1, 1'b1);
    drive(1'b1, 10);
    chk("01_data", data_out, 8'h01); chk("01_perr", parity_err, 1);
    ack();
    send(8'h00, 1'b1, 1'b1);
    drive(1'b1, 10);
    chk("00_perr", parity_err, 0); chk("00_valid", rx_valid, 1);
    ack();
    send(8'hFF, 1'b0, 1'b0);
    drive(1'b0, 40);
    chk("ff_data", data_out, 8'hFF); chk("ff_ferr", frame_err, 1); chk("ff_busy", rx_busy, 0);
    drive(1'b1, 20);
    ack();
    drive(1'b1, 5);
    chk("ff_no_spurious", rx_valid, 0);
    send(8'h3C, 1'b1, 1'b1);
    drive(1'b1, 10);
    chk("3c_data", data_out, 8'h3C); chk("3c_ferr", frame_err, 0);
    ack();
    drive(1'b0, 8);
    drive(1'b1, 20);
    chk("glitch_valid", rx_valid, 0); chk("glitch_busy", rx_busy, 0); chk("glitch_data", data_out, 8'h3C);
    send(8'h11, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b1);
    drive(1'b1, 10);
    chk("b2b_data", data_out, 8'h22); chk("b2b_ovr", overrun, 1);
    ack();
    chk("b2b_ack_valid", rx_valid, 0); chk("b2b_ack_ovr", overrun, 0);
    fork
      begin send(8'h11, 1'b1, 1'b1); send(8'h22, 1'b1, 1'b1); end
      begin tick(346); ack(); end
    join
    drive(1'b1, 10);
    chk("b2b_same_ovr", overrun, 0); chk("b2b_same_valid", rx_valid, 1); chk("b2b_same_data", data_out, 8'h22);
    drive(1'b0, 16);
    drive(1'b0, 16); drive(1'b1, 16); drive(1'b0, 16); drive(1'b1, 16);
    drive(1'b1, 8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_data", data_out, 0); chk("rst_valid", rx_valid, 0); chk("rst_busy", rx_busy, 0);
    chk("rst_ovr", overrun, 0); chk("rst_perr", parity_err, 0); chk("rst_ferr", frame_err, 0);
    drive(1'b1, 40);
    send(8'h5A, 1'b1, 1'b1);
    drive(1'b1, 10);
    chk("5a_data", data_out, 8'h5A); chk("5a_valid", rx_valid, 1); chk("5a_perr", parity_err, 0);
    ack();
    fork
      while (!rand_done) begin
        rx_ack = ($urandom_range(7) == 0);
        tick(1);
      end
      begin
        for (int k = 0; k < 50; k++) begin
          drive(1'b1, $urandom_range(40, 1));
          if ($urandom_range(4) == 0) begin
            drive(1'b0, $urandom_range(8, 1));
            drive(1'b1, 12);
          end
          send(8'($urandom), 1'($urandom), $urandom_range(3) != 0);
        end
        drive(1'b1, 30);
        rand_done = 1;
      end
    join
    rx_ack = 1'b0;
    drive(1'b1, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
